// File: rtl/ro_puf_sequencer_pkg.sv
// Shared definitions for the ring-oscillator PUF sequencer.
//   state_t       : sequencer FSM states
//   DEF_WINDOW    : default oscillator enable window in clk cycles
//   DEF_SYNC_DLY  : default settle delay after the window closes
//   clog2_min1()  : ceil(log2(n)) clamped to at least 1 bit
//   sel_width()   : RO select width for a given oscillator count
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        COMPARE,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_WINDOW   = 1024;
    localparam int DEF_SYNC_DLY = 2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sel_width(input int n_ro);
        return clog2_min1(n_ro);
    endfunction

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Bundle of host-side and datapath-side signals of the PUF sequencer.
//   master : host + RO datapath (drives start/abort/challenge and counts)
//   slave  : the sequencer (drives selects, counter control, results)
// Signals:
//   start, abort, challenge     host request
//   busy, resp_valid, response  host status/result
//   tie_mask, bad_mask          per-pair quality flags
//   sel_a, sel_b, cnt_clr, ro_en  datapath control
//   cnt_a, cnt_b                datapath counts
interface ro_puf_sequencer_if
    import ro_puf_pkg::*;
#(
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16
);
    logic                         start;
    logic                         abort;
    logic [RESP_BITS*2*SEL_W-1:0] challenge;
    logic [CNT_W-1:0]             cnt_a;
    logic [CNT_W-1:0]             cnt_b;
    logic [SEL_W-1:0]             sel_a;
    logic [SEL_W-1:0]             sel_b;
    logic                         cnt_clr;
    logic                         ro_en;
    logic                         busy;
    logic                         resp_valid;
    logic [RESP_BITS-1:0]         response;
    logic [RESP_BITS-1:0]         tie_mask;
    logic [RESP_BITS-1:0]         bad_mask;

    modport master (
        output start, abort, challenge, cnt_a, cnt_b,
        input  sel_a, sel_b, cnt_clr, ro_en, busy, resp_valid,
               response, tie_mask, bad_mask
    );

    modport slave (
        input  start, abort, challenge, cnt_a, cnt_b,
        output sel_a, sel_b, cnt_clr, ro_en, busy, resp_valid,
               response, tie_mask, bad_mask
    );
endinterface

// File: rtl/ro_puf_sequencer_window_timer.sv
// Loadable down-counter timing both the oscillator window and the
// post-window settle delay.
//   clk, reset : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : value loaded; the phase then lasts load_val+1 cycles
//   en         : count down by one per cycle, stops at zero
//   zero       : count is zero (last cycle of the timed phase)
module ro_puf_window_timer
    import ro_puf_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer. For each challenge pair it selects two
// oscillators, clears the counters, runs them for a fixed window, waits
// for the counts to settle and records one response bit (A faster than B).
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave side of ro_puf_sequencer_if (host request/result
//                and RO datapath control/counts)
// All outputs are flops; they are computed from the next state so that
// each output lines up with the state it belongs to.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int N_RO      = 16,
    parameter int RESP_BITS = 8,
    parameter int CNT_W     = 16,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int SYNC_DLY  = DEF_SYNC_DLY
) (
    input  logic clk,
    input  logic reset,
    ro_puf_sequencer_if.slave bus
);
    localparam int SEL_W   = sel_width(N_RO);
    localparam int PAIR_W  = 2 * SEL_W;
    localparam int CHAL_W  = RESP_BITS * PAIR_W;
    localparam int IDX_W   = clog2_min1(RESP_BITS);
    localparam int TMR_MAX = (WINDOW > SYNC_DLY + 1) ? WINDOW : SYNC_DLY + 1;
    localparam int TMR_W   = clog2_min1(TMR_MAX);

    // Timer load values: a phase lasts load+1 cycles.
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] DRN_LOAD = TMR_W'((SYNC_DLY > 0) ? SYNC_DLY - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    state_t               state_q, state_d;
    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic                 cnt_clr_q, cnt_clr_d;
    logic                 ro_en_q, ro_en_d;
    logic                 busy_q, busy_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [RESP_BITS-1:0] tie_q, tie_d;
    logic [RESP_BITS-1:0] bad_q, bad_d;

    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic [PAIR_W-1:0]    pair_d;
    logic                 tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0]     tmr_val;

    assign cnt_a = bus.cnt_a;
    assign cnt_b = bus.cnt_b;

    ro_puf_window_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        bad_d   = bad_q;

        // Abort overrides every transition and freezes partial results.
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        chal_d  = bus.challenge;
                        idx_d   = '0;
                        resp_d  = '0;
                        tie_d   = '0;
                        bad_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    // Identical selects would only measure noise: flag and skip.
                    if (sel_a_q == sel_b_q) begin
                        bad_d[idx_q]  = 1'b1;
                        resp_d[idx_q] = 1'b0;
                        state_d       = NEXT;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tmr_zero) begin
                        state_d = (SYNC_DLY > 0) ? DRAIN : COMPARE;
                    end
                end
                DRAIN: begin
                    if (tmr_zero) begin
                        state_d = COMPARE;
                    end
                end
                COMPARE: begin
                    resp_d[idx_q] = (cnt_a > cnt_b);
                    tie_d[idx_q]  = (cnt_a == cnt_b);
                    state_d       = NEXT;
                end
                NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Selects are loaded on entry to LOAD so they are stable while the
        // counters clear, and held everywhere else (including IDLE).
        pair_d  = chal_d[int'(idx_d) * PAIR_W +: PAIR_W];
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (state_d == LOAD) begin
            sel_a_d = pair_d[PAIR_W-1:SEL_W];
            sel_b_d = pair_d[SEL_W-1:0];
        end

        cnt_clr_d    = (state_d == LOAD);
        ro_en_d      = (state_d == RUN);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == DONE);

        // Timer is armed on entry to RUN or DRAIN; it saturates at zero.
        tmr_load = ((state_d == RUN)   && (state_q != RUN)) ||
                   ((state_d == DRAIN) && (state_q != DRAIN));
        tmr_val  = (state_d == RUN) ? WIN_LOAD : DRN_LOAD;
        tmr_en   = (state_q == RUN) || (state_q == DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            chal_q       <= '0;
            idx_q        <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            cnt_clr_q    <= 1'b0;
            ro_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            tie_q        <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            idx_q        <= idx_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            cnt_clr_q    <= cnt_clr_d;
            ro_en_q      <= ro_en_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            tie_q        <= tie_d;
            bad_q        <= bad_d;
        end
    end

    assign bus.sel_a      = sel_a_q;
    assign bus.sel_b      = sel_b_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.ro_en      = ro_en_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.response   = resp_q;
    assign bus.tie_mask   = tie_q;
    assign bus.bad_mask   = bad_q;
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer with a behavioural RO/counter
// datapath: oscillator s has period ro_period(s) in units where one clk
// cycle is 10; counts accumulate while ro_en is high and clear on cnt_clr.
module tb_ro_puf_sequencer;
    localparam int N_RO      = 16;
    localparam int SEL_W     = 4;
    localparam int RESP_BITS = 4;
    localparam int CNT_W     = 8;
    localparam int WINDOW    = 16;
    localparam int SYNC_DLY  = 2;
    localparam int PAIR_W    = 2 * SEL_W;
    localparam int CHAL_W    = RESP_BITS * PAIR_W;
    localparam int MAXC      = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ro_puf_sequencer_if #(.RESP_BITS(RESP_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    ro_puf_sequencer #(
        .N_RO(N_RO), .RESP_BITS(RESP_BITS), .CNT_W(CNT_W),
        .WINDOW(WINDOW), .SYNC_DLY(SYNC_DLY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int ro_period(input int s);
        if (s == 8)  return 12;
        if (s == 12) return 15;
        return 20 + s;
    endfunction

    // ---------------- behavioural datapath ----------------
    logic [CNT_W-1:0] ca_q, cb_q;
    int               pa_q, pb_q;
    bit               force_tie = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ca_q <= '0; cb_q <= '0; pa_q <= 0; pb_q <= 0;
        end else if (bus.cnt_clr) begin
            ca_q <= '0; cb_q <= '0; pa_q <= 0; pb_q <= 0;
        end else if (bus.ro_en) begin
            ca_q <= ca_q + CNT_W'((pa_q + 10) / ro_period(int'(bus.sel_a)));
            pa_q <= (pa_q + 10) % ro_period(int'(bus.sel_a));
            cb_q <= cb_q + CNT_W'((pb_q + 10) / ro_period(int'(bus.sel_b)));
            pb_q <= (pb_q + 10) % ro_period(int'(bus.sel_b));
        end
    end

    // Pair {3,7} can be forced to a tie of 40/40.
    assign bus.cnt_a = (force_tie && bus.sel_a == 4'd3 && bus.sel_b == 4'd7) ? CNT_W'(40) : ca_q;
    assign bus.cnt_b = (force_tie && bus.sel_a == 4'd3 && bus.sel_b == 4'd7) ? CNT_W'(40) : cb_q;

    // ---------------- protocol monitor ----------------
    int overlap_cnt = 0;
    int rv_cnt      = 0;
    int run_len     = 0;
    int runs[$];

    always @(negedge clk) begin
        if (!reset) begin
            run_len <= 0;
        end else begin
            if (bus.ro_en && bus.cnt_clr) overlap_cnt <= overlap_cnt + 1;
            if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
            if (bus.ro_en) begin
                run_len <= run_len + 1;
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len <= 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int nbad  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: count = floor(10*WINDOW/period), bit = A count > B count.
    task automatic ref_eval(input logic [CHAL_W-1:0] chal, input bit tie,
                            output logic [RESP_BITS-1:0] rr, output logic [RESP_BITS-1:0] tt,
                            output logic [RESP_BITS-1:0] bb, output int lat, output int nrun);
        logic [PAIR_W-1:0] pr;
        int sa, sb, na, nb;
        rr = '0; tt = '0; bb = '0; lat = 1; nrun = 0;
        for (int i = 0; i < RESP_BITS; i++) begin
            pr = chal[i*PAIR_W +: PAIR_W];
            sa = int'(pr[7:4]);
            sb = int'(pr[3:0]);
            if (sa == sb) begin
                bb[i] = 1'b1;
                lat += 2;
            end else begin
                na = (WINDOW * 10) / ro_period(sa);
                nb = (WINDOW * 10) / ro_period(sb);
                if (tie && sa == 3 && sb == 7) begin na = 40; nb = 40; end
                rr[i] = (na > nb);
                tt[i] = (na == nb);
                lat += 1 + WINDOW + SYNC_DLY + 1 + 1;
                nrun++;
            end
        end
    endtask

    // Called just after a falling edge with the DUT idle. Cycle 1 is the
    // first cycle after the accepting rising edge.
    task automatic do_req(input logic [CHAL_W-1:0] chal, input bit tie,
                          output logic [RESP_BITS-1:0] r, output logic [RESP_BITS-1:0] t,
                          output logic [RESP_BITS-1:0] b, output int lat, output int nv);
        r = 'x; t = 'x; b = 'x; lat = -1; nv = 0;
        force_tie     = tie;
        bus.challenge = chal;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= MAXC; c++) begin
            if (bus.resp_valid) begin
                if (nv == 0) lat = c;
                nv++;
                r = bus.response; t = bus.tie_mask; b = bus.bad_mask;
            end
            if (!bus.busy) break;
            @(negedge clk);
        end
        if (bus.busy) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
        end
    endtask

    task automatic check_req(input string nm, input logic [CHAL_W-1:0] chal, input bit tie,
                             input logic [RESP_BITS-1:0] er, input logic [RESP_BITS-1:0] et,
                             input logic [RESP_BITS-1:0] eb, input int elat, input int enrun);
        logic [RESP_BITS-1:0] r, t, b;
        int lat, nv, badrun;
        runs.delete();
        do_req(chal, tie, r, t, b, lat, nv);
        badrun = 0;
        foreach (runs[k]) if (runs[k] != WINDOW) badrun++;
        chk({nm, "_resp"},    32'(r), 32'(er));
        chk({nm, "_tie"},     32'(t), 32'(et));
        chk({nm, "_bad"},     32'(b), 32'(eb));
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_nvalid"},  32'(nv), 32'd1);
        chk({nm, "_nruns"},   32'(runs.size()), 32'(enrun));
        chk({nm, "_runlen"},  32'(badrun), 32'd0);
    endtask

    typedef struct {
        logic [CHAL_W-1:0]    chal;
        bit                   tie;
        logic [RESP_BITS-1:0] resp;
        logic [RESP_BITS-1:0] tiem;
        logic [RESP_BITS-1:0] badm;
        int                   lat;
        int                   nrun;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        vec_t                 vt[4];
        logic [CHAL_W-1:0]    rc;
        logic [RESP_BITS-1:0] er, et, eb, r, t, b;
        int                   elat, enrun, lat, nv, rises, guard, rv0;
        logic                 prev;

        vt[0] = '{32'h8CC88CC8, 1'b0, 4'b1010, 4'b0000, 4'b0000, 85, 4};
        vt[1] = '{32'h8CC855C8, 1'b0, 4'b1000, 4'b0000, 4'b0010, 66, 3};
        vt[2] = '{32'h8C378CC8, 1'b1, 4'b1010, 4'b0100, 4'b0000, 85, 4};
        vt[3] = '{32'h33221100, 1'b0, 4'b0000, 4'b0000, 4'b1111,  9, 0};

        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.challenge = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({bus.busy, bus.ro_en, bus.cnt_clr, bus.resp_valid}), 32'd0);
        chk("reset_sel",  32'({bus.sel_a, bus.sel_b}), 32'd0);
        chk("reset_res",  32'({bus.response, bus.tie_mask, bus.bad_mask}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            check_req($sformatf("vec%0d", i), vt[i].chal, vt[i].tie,
                      vt[i].resp, vt[i].tiem, vt[i].badm, vt[i].lat, vt[i].nrun);
        end

        // Random challenges against the reference model.
        for (int i = 0; i < 8; i++) begin
            rc = CHAL_W'($urandom);
            if (i % 3 == 0) rc[15:8] = {rc[11:8], rc[11:8]};
            ref_eval(rc, 1'b0, er, et, eb, elat, enrun);
            check_req($sformatf("rand%0d", i), rc, 1'b0, er, et, eb, elat, enrun);
        end

        // start while busy is ignored; the first challenge is kept.
        fork
            do_req(32'h8CC88CC8, 1'b0, r, t, b, lat, nv);
            begin
                repeat (10) @(negedge clk);
                bus.challenge = 32'hC88CC88C;
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        chk("busy_start_resp", 32'(r), 32'(4'b1010));
        chk("busy_start_lat",  32'(lat), 32'd85);

        // Abort during RUN of pair 1.
        bus.challenge = 32'h8CC88C8C;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rises = 0; guard = 0; prev = 1'b0;
        while (rises < 2 && guard < MAXC) begin
            @(negedge clk);
            guard++;
            if (bus.ro_en && !prev) rises++;
            prev = bus.ro_en;
        end
        chk("abort_reach_run", 32'(rises), 32'd2);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        rv0 = rv_cnt;
        @(posedge clk);
        #1;
        chk("abort_ro_en", 32'(bus.ro_en), 32'd0);
        chk("abort_busy",  32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_partial", 32'({bus.response, bus.tie_mask, bus.bad_mask}), 32'h100);
        repeat (40) @(negedge clk);
        chk("abort_no_valid", 32'(rv_cnt - rv0), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        check_req("after_abort", vt[0].chal, 1'b0, vt[0].resp, vt[0].tiem, vt[0].badm, 85, 4);

        // abort and start together in IDLE: abort wins.
        bus.challenge = 32'h8CC88CC8;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("abort_start_busy2", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of RUN.
        bus.challenge = 32'h8CC88CC8;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!bus.ro_en && guard < MAXC) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_reach_run", 32'(bus.ro_en), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_ro_en", 32'(bus.ro_en), 32'd0);
        chk("rst_ctrl",  32'({bus.busy, bus.cnt_clr, bus.resp_valid}), 32'd0);
        chk("rst_sel",   32'({bus.sel_a, bus.sel_b}), 32'd0);
        chk("rst_res",   32'({bus.response, bus.tie_mask, bus.bad_mask}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_req("after_reset", vt[1].chal, 1'b0, vt[1].resp, vt[1].tiem, vt[1].badm, 66, 3);

        chk("ro_en_cnt_clr_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule

// File: doc/ro_puf_sequencer.md
Name: ro_puf_sequencer

Overview:
Controller that sequences the ring-oscillator PUF counter datapath to produce a multi-bit response from a multi-pair challenge. For each challenge pair it drives the two RO selects, clears the counters, enables the oscillators for a fixed clock-timed window and waits for counter synchronisation. It then compares the two counts and shifts one response bit. It sits between the host/bus interface and the RO array plus counter pair.

Parameters:
N_RO, 16, number of ring oscillators; select width SEL_W = clog2(N_RO) = 4
RESP_BITS, 8, response bits per request, one per challenge pair
CNT_W, 16, width of each datapath counter value
WINDOW, 1024, ro_en high time in clk cycles (>=1)
SYNC_DLY, 2, wait cycles after ro_en falls before counts are sampled (>=0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; accepted only when busy=0
abort  in  1  synchronous abort; returns to IDLE
challenge  in  RESP_BITS*2*SEL_W  pair i = {sel_a,sel_b} at bits [i*8+7:i*8]; sel_a is upper nibble
cnt_a  in  CNT_W  count of selected RO A, from datapath
cnt_b  in  CNT_W  count of selected RO B, from datapath
sel_a  out  SEL_W  RO A select to datapath
sel_b  out  SEL_W  RO B select to datapath
cnt_clr  out  1  counter clear pulse to datapath
ro_en  out  1  oscillator/count enable
busy  out  1  request in progress
resp_valid  out  1  one-cycle pulse when response is complete
response  out  RESP_BITS  response; bit i from pair i
tie_mask  out  RESP_BITS  bit i set if pair i counts were equal
bad_mask  out  RESP_BITS  bit i set if pair i had sel_a==sel_b

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0, including sel_a, sel_b, response and both masks. The challenge register and pair index are cleared.
- IDLE: busy=0. When start=1, the challenge is registered, the pair index is set to 0, response and both masks are cleared, and the FSM goes to LOAD. start is ignored when busy=1.
- LOAD (1 cycle): sel_a/sel_b take pair[idx] and cnt_clr=1. If sel_a==sel_b, set bad_mask[idx], set response[idx]=0, and go to NEXT without measuring. Otherwise go to RUN.
- RUN (exactly WINDOW cycles): ro_en=1. The window timer counts down from WINDOW-1. At 0 the FSM goes to DRAIN.
- DRAIN (SYNC_DLY cycles, skipped if 0): ro_en=0 and selects are held.
- COMPARE (1 cycle): response[idx] = (cnt_a > cnt_b), unsigned compare. If cnt_a==cnt_b, response[idx]=0 and tie_mask[idx]=1.
- NEXT (1 cycle): if idx==RESP_BITS-1, go to DONE. Otherwise increment idx and go to LOAD.
- DONE (1 cycle): resp_valid=1, then the FSM goes to IDLE.
- Hold rules: response and masks hold until the next accepted start. sel_a and sel_b hold their last value while in IDLE.
- Latency per measured pair: 1+WINDOW+SYNC_DLY+1+1 cycles. Per bad pair: 2 cycles. From the start-accept edge to the resp_valid cycle: sum over pairs, plus 1.
- busy=1 in every state except IDLE.
- abort has priority over all transitions. The next state is IDLE, ro_en and cnt_clr drop in the same cycle as the transition, and no resp_valid is issued. Response and masks keep partial values.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Reset mid-run: ro_en deasserts asynchronously.
- ro_en and cnt_clr are registered outputs with no glitches. ro_en is never high in the same cycle as cnt_clr.
- Index counter width is clog2(RESP_BITS), minimum 1, with no wrap beyond RESP_BITS-1.

Decomposition:
- Package ro_puf_pkg:
  - state enum {IDLE, LOAD, RUN, DRAIN, COMPARE, NEXT, DONE}
  - SEL_W derivation function
  - default WINDOW/SYNC_DLY constants
- Sub-module ro_puf_window_timer: loadable down-counter with load, en and zero flag, width clog2(max(WINDOW,SYNC_DLY+1)). It is reused for both RUN and DRAIN.

Test Plan:
- Simulation parameters: WINDOW=16, SYNC_DLY=2, RESP_BITS=4, CNT_W=8. Behavioural datapath model: counts increment by RO-model toggles, RO8 period 12, RO12 period 15.
- Basic: challenge pair0={4'hC,4'h8}, pairs1-3={8,C},{C,8},{8,C}; start -> response=4'b1010, masks 0, resp_valid exactly 1 cycle, 4*21+1=85 cycles after the accept edge.
- Bad pair: pair1={5,5}, others as above -> bad_mask=4'b0010, response[1]=0, only 2 cycles spent on pair1, ro_en never high for pair1.
- Tie: datapath forces cnt_a=cnt_b=8'd40 for pair2 -> tie_mask=4'b0100, response[2]=0.
- Abort in RUN of pair1 -> next cycle ro_en=0, busy=0, no resp_valid; a new start then completes normally.
- start while busy=1 -> ignored, challenge register unchanged. reset=0 asserted mid-RUN -> ro_en, busy and all outputs 0 immediately.
- Protocol checks (assertions): ro_en&cnt_clr never both high; ro_en high count per measured pair = 16.
